pmem_burst_adaptor: RTL
=======================

# pmem_burst_adaptor

Responder for the L2 cache's physical-memory port: accepts one 256-bit line read or write per transaction and converts it into a 4-beat, 64-bit burst on the main-memory bus. It sits between the L2 cache (pmem side) and the DRAM model or controller. It holds a single transaction in flight and acknowledges with a one-cycle `pmem_resp` pulse once the burst completes.

## Interface
- `LINE_W`, default 256: cache line width in bits.
- `BEAT_W`, default 64: memory bus width; `BEATS = LINE_W/BEAT_W` (4).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `pmem_read`  in  1  line read request from the L2; held until `pmem_resp`.
- `pmem_write`  in  1  line write request from the L2; held until `pmem_resp`.
- `pmem_address`  in  32  line address.
- `pmem_wdata`  in  LINE_W  write line.
- `pmem_rdata`  out  LINE_W  assembled read line.
- `pmem_resp`  out  1  transaction-complete pulse.
- `address_o`  out  32  burst address to memory.
- `burst_o`  out  BEAT_W  write beat.
- `burst_i`  in  BEAT_W  read beat.
- `read_o`  out  1  memory read request.
- `write_o`  out  1  memory write request.
- `resp_i`  in  1  memory beat acknowledge/valid.

## Operation
- The FSM has four states: IDLE, RD_BURST, WR_BURST and DONE. A 2-bit beat counter `cnt` is cleared on entry to either burst state.
- **IDLE:**
  - If `pmem_write` is high, the block latches the address and `pmem_wdata` into internal registers and moves to WR_BURST.
  - Otherwise, if `pmem_read` is high, it latches the address and moves to RD_BURST.
  - If both are high, the write wins. This case is illegal from the cache but must be deterministic.
  - `resp_i` is ignored in IDLE.
- **RD_BURST:**
  - `read_o` is 1 and `address_o` is the latched address.
  - On each cycle with `resp_i` high, `burst_i` is stored to line bits `[cnt*64 +: 64]` (beat 0 = bits 63:0) and `cnt` increments.
  - On the resp of beat 3, the state moves to DONE.
- **WR_BURST:**
  - `write_o` is 1 and `burst_o` is latched wdata `[cnt*64 +: 64]`.
  - Each `resp_i` advances `cnt`. On the resp of beat 3, the state moves to DONE.
- **DONE:**
  - `pmem_resp` is 1 for exactly one cycle, then the state moves to IDLE.
  - `pmem_rdata` is updated to the assembled line on entry to DONE and then held until the next read completes. Writes never change `pmem_rdata`.
- The `read_o`/`write_o`/`address_o`/`burst_o` outputs are decoded from registered state. `read_o` and `write_o` are never both high. `resp_i` gaps (low cycles mid-burst) stall without losing beats.
- Request inputs are sampled only in IDLE. Changes to `pmem_address`/`pmem_wdata` mid-burst have no effect.

## Timing
- Reset values:
  - state IDLE, `cnt` 0.
  - `pmem_rdata` 0, `pmem_resp` 0.
  - `read_o` 0, `write_o` 0.
  - `address_o` 0, `burst_o` 0.
- For a request first seen in IDLE at cycle 0:
  - `read_o`/`write_o` rise at cycle 1.
  - Memory may assert `resp_i` from cycle 2 onward.
  - With zero-wait memory (resp_i high cycles 2–5), `pmem_resp` is high at cycle 6 and the block is IDLE at cycle 7.
  - Minimum request-to-resp latency is therefore 6 cycles; each stall cycle adds one.
- IDLE may accept a new request in the cycle immediately after DONE (back-to-back throughput: 7 cycles per line at zero wait).
- Reset mid-burst:
  - The block returns to IDLE on the next edge and `read_o`/`write_o` drop.
  - The partial line is discarded and `pmem_rdata` is cleared to 0.
  - No `pmem_resp` is issued.
- `resp_i` in DONE is ignored. `resp_i` held high beyond beat 3 does not start a new transaction.

## Configuration
- Macro: `PMEM_ADDR_ALIGN_EN`.
- Defined: the latched address has bits [4:0] forced to 0, so `address_o` is always 32-byte line aligned.
- Undefined: `address_o` equals `pmem_address` as sampled, unmodified.

## Test plan
- Read, zero-wait: `pmem_read`=1, addr 0x0000_1040, `burst_i` = 0x11..11, 0x22..22, 0x33..33, 0x44..44 on cycles 2–5 -> `read_o` high cycles 1–5, `pmem_resp` pulse at cycle 6, `pmem_rdata` = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Write with stall: `pmem_write`=1, wdata beats A/B/C/D, `resp_i` pattern 1,0,1,1,1 -> `burst_o` shows A, B, B, C, D, `write_o` drops after the fourth resp, one `pmem_resp`, and `pmem_rdata` unchanged.
- Simultaneous `pmem_read` and `pmem_write` in IDLE -> WR_BURST taken, `write_o`=1, `read_o` stays 0.
- `rst` asserted after beat 2 of a read -> next cycle `read_o`=0, `pmem_rdata`=0, no `pmem_resp`; a fresh read then completes normally.
- Addr 0x0000_105C: with `PMEM_ADDR_ALIGN_EN` -> `address_o`=0x0000_1040; without -> `address_o`=0x0000_105C.
- Back-to-back reads held continuously -> `pmem_resp` pulses at cycles 6 and 13, each exactly one cycle wide.

Source files
------------

// File: rtl/pmem_burst_adaptor.sv
// L2 physical-memory responder: one 256-bit line per transaction, carried as a 4-beat burst on a 64-bit memory bus.
// Optional feature macro PMEM_ADDR_ALIGN_EN: when defined, the latched address is forced to 32-byte line alignment.
module pmem_burst_adaptor #(
   parameter int LINE_W = 256,
   parameter int BEAT_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pmem_read,
   input  logic              pmem_write,
   input  logic [31:0]       pmem_address,
   input  logic [LINE_W-1:0] pmem_wdata,
   output logic [LINE_W-1:0] pmem_rdata,
   output logic              pmem_resp,
   output logic [31:0]       address_o,
   output logic [BEAT_W-1:0] burst_o,
   input  logic [BEAT_W-1:0] burst_i,
   output logic              read_o,
   output logic              write_o,
   input  logic              resp_i
);

   localparam int BEATS = LINE_W / BEAT_W;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

   state_t              state_reg;
   logic [CNT_W-1:0]    cnt_reg;
   logic [31:0]         addr_reg;
   logic [31:0]         addr_next;
   logic [LINE_W-1:0]   wdata_reg;
   logic [LINE_W-1:0]   line_reg;
   logic [LINE_W-1:0]   line_next;
   logic [BEAT_W-1:0]   wbeat [BEATS];
   logic                last_beat;

`ifdef PMEM_ADDR_ALIGN_EN
   assign addr_next = {pmem_address[31:5], 5'b0};
`else
   assign addr_next = pmem_address;
`endif

   // Split the write line into beats and merge the incoming read beat into its slot.
   generate
      for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
         assign wbeat[gi] = wdata_reg[gi*BEAT_W +: BEAT_W];
         assign line_next[gi*BEAT_W +: BEAT_W] =
            (cnt_reg == CNT_W'(gi)) ? burst_i : line_reg[gi*BEAT_W +: BEAT_W];
      end
   endgenerate

   assign last_beat = resp_i && (cnt_reg == CNT_W'(BEATS - 1));
   assign read_o    = (state_reg == RD_BURST);
   assign write_o   = (state_reg == WR_BURST);
   assign address_o = addr_reg;
   assign burst_o   = write_o ? wbeat[cnt_reg] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         addr_reg   <= '0;
         wdata_reg  <= '0;
         line_reg   <= '0;
         pmem_rdata <= '0;
         pmem_resp  <= 1'b0;
      end else begin
         pmem_resp <= 1'b0;
         case (state_reg)
            IDLE: begin
               // Write has priority if the cache ever raises both.
               if (pmem_write) begin
                  addr_reg  <= addr_next;
                  wdata_reg <= pmem_wdata;
                  cnt_reg   <= '0;
                  state_reg <= WR_BURST;
               end else if (pmem_read) begin
                  addr_reg  <= addr_next;
                  cnt_reg   <= '0;
                  state_reg <= RD_BURST;
               end
            end
            RD_BURST: begin
               if (resp_i) begin
                  line_reg <= line_next;
                  cnt_reg  <= cnt_reg + 1'b1;
                  if (last_beat) begin
                     pmem_rdata <= line_next;
                     pmem_resp  <= 1'b1;
                     state_reg  <= DONE;
                  end
               end
            end
            WR_BURST: begin
               if (resp_i) begin
                  cnt_reg <= cnt_reg + 1'b1;
                  if (last_beat) begin
                     pmem_resp <= 1'b1;
                     state_reg <= DONE;
                  end
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule
